// File: rtl/apb_rr_master.sv
// APB master sharing two slaves between two requesters with round-robin arbitration.
// One command in flight: accept, SETUP, ACCESS until PREADY or timeout, then a one-cycle done pulse.
module apb_rr_master #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PENABLE,
  output logic              PSELECT1,
  output logic              PSELECT2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY1,
  input  logic              PREADY2
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic              psel1_q, psel1_d;
  logic              psel2_q, psel2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              grant0, grant1;
  logic [ADDR_W-1:0] win_addr;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              finish, timed_out;

  // prio_q=0 means requester 0 wins when both are valid
  assign grant0    = (state_q == IDLE) && !PRESET && req0_valid && (!req1_valid || !prio_q);
  assign grant1    = (state_q == IDLE) && !PRESET && req1_valid && (!req0_valid || prio_q);
  assign win_addr  = grant1 ? req1_addr : req0_addr;
  assign sel_ready = psel2_q ? PREADY2 : PREADY1;
  assign sel_rdata = psel2_q ? PRDATA2 : PRDATA1;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    cnt_d     = cnt_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d     = grant1;
          prio_d   = grant0;
          paddr_d  = {1'b0, win_addr[ADDR_W-2:0]};
          pwdata_d = grant1 ? req1_wdata : req0_wdata;
          pwrite_d = grant1 ? req1_write : req0_write;
          psel1_d  = !win_addr[ADDR_W-1];
          psel2_d  = win_addr[ADDR_W-1];
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          finish = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d   = IDLE;
      psel1_d   = 1'b0;
      psel2_d   = 1'b0;
      penable_d = 1'b0;
      if (id_q) begin
        done1_d = 1'b1;
        err1_d  = timed_out;
        if (timed_out)      rdata1_d = '0;
        else if (!pwrite_q) rdata1_d = sel_rdata;
      end else begin
        done0_d = 1'b1;
        err0_d  = timed_out;
        if (timed_out)      rdata0_d = '0;
        else if (!pwrite_q) rdata0_d = sel_rdata;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      id_q      <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      cnt_q     <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      id_q      <= id_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      cnt_q     <= cnt_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PWRITE     = pwrite_q;
  assign PENABLE    = penable_q;
  assign PSELECT1   = psel1_q;
  assign PSELECT2   = psel2_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: transaction-level reference model, two slave models, directed and random traffic.
module tb_apb_rr_master;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE, PENABLE, PSELECT1, PSELECT2;
  logic [DW-1:0] PRDATA1 = '0, PRDATA2 = '0;
  logic          PREADY1 = 1'b0, PREADY2 = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  apb_rr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSELECT1(PSELECT1), .PSELECT2(PSELECT2),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  // slave wait states before PREADY for the next accepted command; stale_hi forces unselected PREADY high
  int next_w = 1;
  bit stale_hi = 1'b0;

  // reference model: a command accepted at an edge occupies 1 SETUP + n ACCESS cycles, then done
  bit            m_busy = 1'b0, m_wr = 1'b0, m_to = 1'b0;
  int            m_prio = 0, m_id = 0, m_w = 1, m_n = 0, m_k = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_mem [0:127];
  logic [AW-1:0] e_paddr = '0;
  logic [DW-1:0] e_pwdata = '0;
  bit            e_pwrite = 1'b0, e_penable = 1'b0, e_psel1 = 1'b0, e_psel2 = 1'b0;
  bit            e_done [2];
  bit            e_err [2];
  logic [DW-1:0] e_rdata [2];

  logic [DW-1:0] s_mem1 [0:63];
  logic [DW-1:0] s_mem2 [0:63];
  int            j1 = 0, j2 = 0;

  logic [AW-1:0] cap_addr;
  logic [1:0]    cap_sel;
  logic          cap_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (PRESET || m_busy) return -1;
    if (req0_valid && (!req1_valid || m_prio == 0)) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge PCLK) begin
    int g;
    if (PRESET) begin
      m_busy = 1'b0; m_prio = 0;
      e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_penable = 1'b0; e_psel1 = 1'b0; e_psel2 = 1'b0;
      e_done[0] = 1'b0; e_done[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
      e_rdata[0] = '0; e_rdata[1] = '0;
    end else begin
      g = model_grant();
      e_done[0] = 1'b0; e_done[1] = 1'b0; e_err[0] = 1'b0; e_err[1] = 1'b0;
      if (g >= 0) begin
        m_busy = 1'b1; m_id = g; m_prio = 1 - g;
        m_wr   = (g == 1) ? req1_write : req0_write;
        m_addr = (g == 1) ? req1_addr  : req0_addr;
        m_wd   = (g == 1) ? req1_wdata : req0_wdata;
        m_w = next_w; m_to = (m_w >= TO); m_n = m_to ? TO : m_w + 1; m_k = 0;
        e_paddr = {1'b0, m_addr[AW-2:0]}; e_pwdata = m_wd; e_pwrite = m_wr;
        e_psel1 = !m_addr[AW-1]; e_psel2 = m_addr[AW-1]; e_penable = 1'b0;
      end else if (m_busy) begin
        m_k++;
        if (m_k <= m_n) begin
          e_penable = 1'b1;
        end else begin
          m_busy = 1'b0; e_psel1 = 1'b0; e_psel2 = 1'b0; e_penable = 1'b0;
          e_done[m_id] = 1'b1; e_err[m_id] = m_to;
          if (m_to)      e_rdata[m_id] = '0;
          else if (m_wr) m_mem[m_addr] = m_wd;
          else           e_rdata[m_id] = m_mem[m_addr];
        end
      end
    end
  end

  // slaves: PREADY rises after m_w ACCESS cycles; the unselected slave drives noise
  always @(negedge PCLK) begin
    j1 = (PSELECT1 && PENABLE) ? j1 + 1 : 0;
    j2 = (PSELECT2 && PENABLE) ? j2 + 1 : 0;
    if (PSELECT1 && PENABLE) begin
      PREADY1 = (j1 > m_w);
      PRDATA1 = s_mem1[PADDR[5:0]];
      if (PREADY1 && PWRITE) s_mem1[PADDR[5:0]] = PWDATA;
    end else begin
      PREADY1 = stale_hi ? 1'b1 : 1'($urandom_range(0, 1));
      PRDATA1 = 8'($urandom);
    end
    if (PSELECT2 && PENABLE) begin
      PREADY2 = (j2 > m_w);
      PRDATA2 = s_mem2[PADDR[5:0]];
      if (PREADY2 && PWRITE) s_mem2[PADDR[5:0]] = PWDATA;
    end else begin
      PREADY2 = stale_hi ? 1'b1 : 1'($urandom_range(0, 1));
      PRDATA2 = 8'($urandom);
    end
  end

  always @(negedge PCLK) begin
    int g;
    g = model_grant();
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("req0_done", req0_done, e_done[0]);
    chk("req1_done", req1_done, e_done[1]);
    chk("req0_err", req0_err, e_err[0]);
    chk("req1_err", req1_err, e_err[1]);
    if (e_done[0]) chk("req0_rdata", req0_rdata, e_rdata[0]);
    if (e_done[1]) chk("req1_rdata", req1_rdata, e_rdata[1]);
    chk("PSELECT1", PSELECT1, e_psel1);
    chk("PSELECT2", PSELECT2, e_psel2);
    chk("PENABLE", PENABLE, e_penable);
    chk("PADDR", PADDR, e_paddr);
    chk("PWDATA", PWDATA, e_pwdata);
    chk("PWRITE", PWRITE, e_pwrite);
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive(input int p, input bit v, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d; end
  endtask

  task automatic run_cmd(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int w, output int lat, output int acc, output logic [DW-1:0] rd, output bit er);
    bit got;
    tick();
    next_w = w;
    drive(p, 1'b1, wr, a, d);
    got = 1'b0; lat = 0; acc = 0; rd = '0; er = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge PCLK);
      got = (p == 0) ? req0_ready : req1_ready;
      if (!got) tick();
    end
    tick();
    drive(p, 1'b0, 1'b0, '0, '0);
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_wait: port %0d never ready", p);
      return;
    end
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge PCLK);
      lat++;
      if (lat == 1) begin cap_addr = PADDR; cap_sel = {PSELECT2, PSELECT1}; cap_en = PENABLE; end
      if (PENABLE) acc++;
      got = (p == 0) ? req0_done : req1_done;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_wait: port %0d no done pulse", p);
      return;
    end
    rd = (p == 0) ? req0_rdata : req1_rdata;
    er = (p == 0) ? req0_err : req1_err;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, acc;
    logic [DW-1:0] rd;
    bit er, got;
    int order [$];
    for (int i = 0; i < 128; i++) m_mem[i] = '0;
    for (int i = 0; i < 64; i++) begin s_mem1[i] = '0; s_mem2[i] = '0; end

    repeat (3) tick();
    chk("rst_rdata0", req0_rdata, 8'h00);
    chk("rst_rdata1", req1_rdata, 8'h00);
    chk("rst_psel1", PSELECT1, 1'b0);
    PRESET = 1'b0;

    // write then read back through slave 1
    run_cmd(0, 1'b1, 7'h05, 8'hA5, 1, lat, acc, rd, er);
    chk("t1_latency", lat, 4);
    chk("t1_access_cycles", acc, 2);
    chk("t1_setup_sel", cap_sel, 2'b01);
    chk("t1_setup_penable", cap_en, 1'b0);
    chk("t1_err", er, 1'b0);
    run_cmd(0, 1'b0, 7'h05, 8'h00, 1, lat, acc, rd, er);
    chk("t1_rdata", rd, 8'hA5);

    // slave 2 via requester 1, offset aliasing with slave 1
    run_cmd(1, 1'b1, 7'h45, 8'h3C, 1, lat, acc, rd, er);
    chk("t2_setup_paddr", cap_addr, 7'h05);
    chk("t2_setup_sel", cap_sel, 2'b10);
    run_cmd(1, 1'b0, 7'h45, 8'h00, 1, lat, acc, rd, er);
    chk("t2_rdata1", rd, 8'h3C);
    run_cmd(0, 1'b0, 7'h05, 8'h00, 1, lat, acc, rd, er);
    chk("t2_rdata0", rd, 8'hA5);

    // timeout, then a normal command
    run_cmd(0, 1'b0, 7'h05, 8'h00, 100, lat, acc, rd, er);
    chk("t4_latency", lat, 6);
    chk("t4_access_cycles", acc, 4);
    chk("t4_err", er, 1'b1);
    chk("t4_rdata", rd, 8'h00);
    chk("t4_psel1_at_done", PSELECT1, 1'b0);
    chk("t4_penable_at_done", PENABLE, 1'b0);
    run_cmd(0, 1'b0, 7'h05, 8'h00, 1, lat, acc, rd, er);
    chk("t4_next_err", er, 1'b0);
    chk("t4_next_rdata", rd, 8'hA5);

    // stale PREADY2 during a slave-1 read
    stale_hi = 1'b1;
    run_cmd(0, 1'b0, 7'h05, 8'h00, 2, lat, acc, rd, er);
    chk("t6_latency", lat, 5);
    chk("t6_rdata", rd, 8'hA5);
    stale_hi = 1'b0;

    // reset in the middle of ACCESS
    tick();
    next_w = 3;
    drive(0, 1'b1, 1'b1, 7'h07, 8'h77);
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge PCLK);
      got = req0_ready;
      if (!got) tick();
    end
    chk("t5_accept", got, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    chk("t5_psel1", PSELECT1, 1'b0);
    chk("t5_penable", PENABLE, 1'b0);
    chk("t5_paddr", PADDR, 7'h00);
    chk("t5_pwdata", PWDATA, 8'h00);
    chk("t5_done0", req0_done, 1'b0);
    PRESET = 1'b0;
    next_w = 1;
    drive(0, 1'b1, 1'b0, 7'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 7'h45, 8'h00);
    @(negedge PCLK);
    chk("t5_ready0", req0_ready, 1'b1);
    chk("t5_ready1", req1_ready, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (8) tick();

    // both requesters valid from reset
    PRESET = 1'b1;
    next_w = 1;
    drive(0, 1'b1, 1'b1, 7'h10, 8'h11);
    drive(1, 1'b1, 1'b1, 7'h51, 8'h22);
    repeat (2) tick();
    PRESET = 1'b0;
    for (int t = 0; t < 60 && order.size() < 4; t++) begin
      @(negedge PCLK);
      if (req0_done) order.push_back(0);
      if (req1_done) order.push_back(1);
      tick();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    chk("t3_done_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) chk($sformatf("t3_done_port_%0d", i), order[i], i % 2);
    repeat (8) tick();

    for (int c = 0; c < 1500; c++) begin
      tick();
      drive(0, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
            {1'($urandom_range(0, 1)), 6'($urandom_range(0, 7))}, 8'($urandom));
      drive(1, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
            {1'($urandom_range(0, 1)), 6'($urandom_range(0, 7))}, 8'($urandom));
      next_w = $urandom_range(0, 5);
      stale_hi = ($urandom_range(0, 3) == 0);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
